// File: rtl/framebuffer_pkg.sv
// framebuffer_pkg: shared types and default sizes
// for the multi-buffered framebuffer.
package framebuffer_pkg;

    localparam int FB_NUM_BUFS    = 2;
    localparam int FB_PIXEL_WIDTH = 8;
    localparam int FB_ADDR_WIDTH  = 17;
    localparam int FB_DEPTH       = 76800;

    typedef logic [1:0] buf_idx_t;

    typedef enum logic [1:0] {
        FB_DRAW,
        FB_WAIT_SWAP,
        FB_CLEAR
    } fb_state_t;

endpackage

// File: rtl/fb_bram.sv
// fb_bram: simple dual-port pixel RAM, one write port
// and one registered, enabled read port.
module fb_bram
    import framebuffer_pkg::*;
#(
    parameter int PIXEL_WIDTH = FB_PIXEL_WIDTH,
    parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int DEPTH       = FB_DEPTH
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [ADDR_WIDTH-1:0]  i_waddr,
    input  logic [PIXEL_WIDTH-1:0] i_wdata,
    input  logic                   i_re,
    input  logic [ADDR_WIDTH-1:0]  i_raddr,
    output logic [PIXEL_WIDTH-1:0] o_rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIXEL_WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]          w_wa;
    logic [IW-1:0]          w_ra;

    // Reads beyond DEPTH are undefined; the upper bits are not needed.
    assign w_wa = i_waddr[IW-1:0];
    assign w_ra = i_raddr[IW-1:0];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_wa] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[w_ra];
        end
    end

endmodule

// File: rtl/framebuffer_nbuf.sv
// framebuffer_nbuf: double/triple buffered pixel store between the
// rasteriser and scan-out; roles rotate on synchronised vsync fall.
module framebuffer_nbuf
    import framebuffer_pkg::*;
#(
    parameter int NUM_BUFS    = FB_NUM_BUFS,
    parameter int PIXEL_WIDTH = FB_PIXEL_WIDTH,
    parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int DEPTH       = FB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vsync,
    input  logic                   wea,
    input  logic [ADDR_WIDTH-1:0]  addra,
    input  logic [PIXEL_WIDTH-1:0] dina,
    input  logic                   frame_done,
    input  logic                   clear_en,
    input  logic [PIXEL_WIDTH-1:0] clear_color,
    output logic                   draw_ready,
    input  logic [ADDR_WIDTH-1:0]  addrb,
    output logic [PIXEL_WIDTH-1:0] doutb,
    output logic [1:0]             disp_idx,
    output logic [15:0]            frame_count,
    output logic                   frame_dropped
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH =
        (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST =
        ADDR_WIDTH'(DEPTH - 1);

    if (!(NUM_BUFS == 2 || NUM_BUFS == 3)) begin : g_bad_bufs
        $error("framebuffer_nbuf: NUM_BUFS must be 2 or 3");
    end
    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("framebuffer_nbuf: DEPTH exceeds address space");
    end

    logic                   r_vs1, r_vs2, r_vs_prev, r_fall;
    fb_state_t              r_state, w_state_nxt;
    buf_idx_t               r_disp, r_draw, r_rdy, r_rd_sel;
    buf_idx_t               w_disp_nxt, w_draw_nxt, w_rdy_nxt;
    logic                   r_rdy_valid, w_rdy_valid_nxt;
    logic [15:0]            r_frame_count, w_frame_count_nxt;
    logic                   r_draw_ready;
    logic                   r_dropped, w_dropped_nxt;
    logic [ADDR_WIDTH-1:0]  r_clr_cnt, w_clr_cnt_nxt, w_waddr;
    logic [PIXEL_WIDTH-1:0] r_clr_color, w_clr_color_nxt, w_wdata;
    logic                   w_we, w_done, w_in_range;
    logic [PIXEL_WIDTH-1:0] w_rd [NUM_BUFS];

    assign w_in_range = ({1'b0, addra} < LP_DEPTH);
    assign w_done     = frame_done && (r_state == FB_DRAW);

    always_comb begin
        w_state_nxt       = r_state;
        w_disp_nxt        = r_disp;
        w_draw_nxt        = r_draw;
        w_rdy_nxt         = r_rdy;
        w_rdy_valid_nxt   = r_rdy_valid;
        w_frame_count_nxt = r_frame_count;
        w_dropped_nxt     = 1'b0;
        w_clr_cnt_nxt     = r_clr_cnt;
        w_clr_color_nxt   = r_clr_color;
        w_we              = 1'b0;
        w_waddr           = addra;
        w_wdata           = dina;

        // Triple-buffer role rotation runs regardless of FSM state.
        if (NUM_BUFS == 3) begin
            if (w_done && r_fall) begin
                w_disp_nxt        = r_draw;
                w_draw_nxt        = r_disp;
                w_rdy_valid_nxt   = 1'b0;
                w_dropped_nxt     = r_rdy_valid;
                w_frame_count_nxt = r_frame_count + 16'd1;
            end else if (w_done) begin
                w_rdy_nxt       = r_draw;
                w_draw_nxt      = r_rdy;
                w_rdy_valid_nxt = 1'b1;
                w_dropped_nxt   = r_rdy_valid;
            end else if (r_fall && r_rdy_valid) begin
                w_disp_nxt        = r_rdy;
                w_rdy_nxt         = r_disp;
                w_rdy_valid_nxt   = 1'b0;
                w_frame_count_nxt = r_frame_count + 16'd1;
            end
        end

        unique case (r_state)
            FB_DRAW: begin
                w_we = wea && w_in_range;
                if (w_done) begin
                    if (NUM_BUFS == 2) begin
                        w_state_nxt = FB_WAIT_SWAP;
                    end else begin
                        w_state_nxt = clear_en ? FB_CLEAR : FB_DRAW;
                    end
                end
            end
            FB_WAIT_SWAP: begin
                if (r_fall) begin
                    w_disp_nxt        = r_draw;
                    w_draw_nxt        = r_disp;
                    w_frame_count_nxt = r_frame_count + 16'd1;
                    w_state_nxt       = clear_en ? FB_CLEAR : FB_DRAW;
                end
            end
            FB_CLEAR: begin
                w_we          = 1'b1;
                w_waddr       = r_clr_cnt;
                w_wdata       = r_clr_color;
                w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
                if (r_clr_cnt == LP_LAST) begin
                    w_state_nxt = FB_DRAW;
                end
            end
            default: w_state_nxt = FB_DRAW;
        endcase

        if (w_state_nxt == FB_CLEAR && r_state != FB_CLEAR) begin
            w_clr_cnt_nxt   = '0;
            w_clr_color_nxt = clear_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs1         <= 1'b0;
            r_vs2         <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_fall        <= 1'b0;
            r_state       <= FB_DRAW;
            r_disp        <= 2'd0;
            r_draw        <= 2'd1;
            r_rdy         <= 2'd2;
            r_rdy_valid   <= 1'b0;
            r_frame_count <= '0;
            r_draw_ready  <= 1'b1;
            r_dropped     <= 1'b0;
            r_clr_cnt     <= '0;
            r_clr_color   <= '0;
            r_rd_sel      <= 2'd0;
        end else begin
            r_vs1         <= vsync;
            r_vs2         <= r_vs1;
            r_vs_prev     <= r_vs2;
            r_fall        <= r_vs_prev & ~r_vs2;
            r_state       <= w_state_nxt;
            r_disp        <= w_disp_nxt;
            r_draw        <= w_draw_nxt;
            r_rdy         <= w_rdy_nxt;
            r_rdy_valid   <= w_rdy_valid_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_draw_ready  <= (w_state_nxt == FB_DRAW);
            r_dropped     <= w_dropped_nxt;
            r_clr_cnt     <= w_clr_cnt_nxt;
            r_clr_color   <= w_clr_color_nxt;
            r_rd_sel      <= r_disp;
        end
    end

    for (genvar g = 0; g < NUM_BUFS; g++) begin : g_buf
        fb_bram #(
            .PIXEL_WIDTH(PIXEL_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH)
        ) u_bram (
            .clk    (clk),
            .i_we   (w_we && (r_draw == buf_idx_t'(g))),
            .i_waddr(w_waddr),
            .i_wdata(w_wdata),
            .i_re   (r_disp == buf_idx_t'(g)),
            .i_raddr(addrb),
            .o_rdata(w_rd[g])
        );
    end

    // Select by the index captured with the read, not the live one.
    always_comb begin
        doutb = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (r_rd_sel == buf_idx_t'(i)) begin
                doutb = w_rd[i];
            end
        end
    end

    assign draw_ready    = r_draw_ready;
    assign disp_idx      = r_disp;
    assign frame_count   = r_frame_count;
    assign frame_dropped = r_dropped;

endmodule

// File: tb/tb_framebuffer_nbuf.sv
// tb_framebuffer_nbuf: double- and triple-buffer instances,
// read data checked through an expected-pixel queue.
module tb_framebuffer_nbuf;
    import framebuffer_pkg::*;

    localparam int PW = 8;
    localparam int AW = 5;
    localparam int DP = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          v2, we2, fd2, ce2, rdy2o, drop2;
    logic [AW-1:0] aa2, ab2;
    logic [PW-1:0] da2, cc2, db2;
    logic [1:0]    di2;
    logic [15:0]   fc2;

    logic          v3, we3, fd3, ce3, rdy3o, drop3;
    logic [AW-1:0] aa3, ab3;
    logic [PW-1:0] da3, cc3, db3;
    logic [1:0]    di3;
    logic [15:0]   fc3;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [PW-1:0] sb [$];
    logic [PW-1:0] exp_px;

    framebuffer_nbuf #(
        .NUM_BUFS(2), .PIXEL_WIDTH(PW),
        .ADDR_WIDTH(AW), .DEPTH(DP)
    ) u_dut2 (
        .clk(clk), .rst(rst), .vsync(v2),
        .wea(we2), .addra(aa2), .dina(da2),
        .frame_done(fd2), .clear_en(ce2),
        .clear_color(cc2), .draw_ready(rdy2o),
        .addrb(ab2), .doutb(db2), .disp_idx(di2),
        .frame_count(fc2), .frame_dropped(drop2)
    );

    framebuffer_nbuf #(
        .NUM_BUFS(3), .PIXEL_WIDTH(PW),
        .ADDR_WIDTH(AW), .DEPTH(DP)
    ) u_dut3 (
        .clk(clk), .rst(rst), .vsync(v3),
        .wea(we3), .addra(aa3), .dina(da3),
        .frame_done(fd3), .clear_en(ce3),
        .clear_color(cc3), .draw_ready(rdy3o),
        .addrb(ab3), .doutb(db3), .disp_idx(di3),
        .frame_count(fc3), .frame_dropped(drop3)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        n_cmp++;
        if (di2 !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_disp2: got %0d want 0", di2);
        end
        n_cmp++;
        if (rdy2o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready2: got %b want 1", rdy2o);
        end
        n_cmp++;
        if (fc2 !== 16'd0 || drop2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cnt2: got %0d/%b want 0/0", fc2, drop2);
        end
        n_cmp++;
        if (di3 !== 2'd0 || rdy3o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_3: got %0d/%b want 0/1", di3, rdy3o);
        end
    endtask

    task automatic test_swap2;
        logic [AW-1:0] ra [3] = '{5'd5, 5'd4, 5'd7};
        logic [PW-1:0] rv [3] = '{8'hAA, 8'h11, 8'h33};
        we2 = 1'b1; aa2 = 5'd5;  da2 = 8'hAA; tick;
        aa2 = 5'd4;  da2 = 8'h11; tick;
        aa2 = 5'd7;  da2 = 8'h33; tick;
        // out of range, must not alias onto address 4
        aa2 = 5'd20; da2 = 8'h77; tick;
        we2 = 1'b0; fd2 = 1'b1; tick;
        fd2 = 1'b0;
        n_cmp++;
        if (rdy2o !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_ready: got %b want 0", rdy2o);
        end
        we2 = 1'b1; aa2 = 5'd7; da2 = 8'h55; tick;
        we2 = 1'b0;
        v2 = 1'b0;
        tick(3);
        n_cmp++;
        if (di2 !== 2'd0) begin
            n_bad++;
            $display("FAIL swap_early: got %0d want 0", di2);
        end
        tick;
        n_cmp++;
        if (di2 !== 2'd1) begin
            n_bad++;
            $display("FAIL swap_disp: got %0d want 1", di2);
        end
        n_cmp++;
        if (rdy2o !== 1'b1 || fc2 !== 16'd1) begin
            n_bad++;
            $display("FAIL swap_state: got %b/%0d want 1/1", rdy2o, fc2);
        end
        v2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ab2 = ra[i];
            sb.push_back(rv[i]);
            tick;
            exp_px = sb.pop_front();
            n_cmp++;
            if (db2 !== exp_px) begin
                n_bad++;
                $display("FAIL rd2_a%0d: got %h want %h", ra[i], db2, exp_px);
            end
        end
        tick(2);
        // second frame draws buffer 0
        we2 = 1'b1; aa2 = 5'd5; da2 = 8'hBB; tick;
        we2 = 1'b0; fd2 = 1'b1; tick;
        fd2 = 1'b0; v2 = 1'b0;
        tick(3);
        ab2 = 5'd5;
        sb.push_back(8'hAA);
        tick;
        n_cmp++;
        if (di2 !== 2'd0 || fc2 !== 16'd2) begin
            n_bad++;
            $display("FAIL swap2_disp: got %0d/%0d want 0/2", di2, fc2);
        end
        exp_px = sb.pop_front();
        n_cmp++;
        if (db2 !== exp_px) begin
            n_bad++;
            $display("FAIL rd_across_swap: got %h want %h", db2, exp_px);
        end
        sb.push_back(8'hBB);
        tick;
        exp_px = sb.pop_front();
        n_cmp++;
        if (db2 !== exp_px) begin
            n_bad++;
            $display("FAIL rd_after_swap: got %h want %h", db2, exp_px);
        end
        v2 = 1'b1;
        tick(4);
    endtask

    task automatic test_clear2;
        int cnt;
        fd2 = 1'b1; tick;
        fd2 = 1'b0;
        ce2 = 1'b1; cc2 = 8'h1F; v2 = 1'b0;
        tick(4);
        v2 = 1'b1; cc2 = 8'h00;
        we2 = 1'b1; aa2 = 5'd3; da2 = 8'h99;
        cnt = 0;
        while (rdy2o === 1'b0 && cnt < 100) begin
            cnt++;
            tick;
        end
        we2 = 1'b0; ce2 = 1'b0;
        n_cmp++;
        if (cnt != 16) begin
            n_bad++;
            $display("FAIL clear_len: got %0d want 16", cnt);
        end
        fd2 = 1'b1; tick;
        fd2 = 1'b0; v2 = 1'b0;
        tick(4);
        v2 = 1'b1;
        n_cmp++;
        if (di2 !== 2'd0 || fc2 !== 16'd4) begin
            n_bad++;
            $display("FAIL clear_disp: got %0d/%0d want 0/4", di2, fc2);
        end
        for (int i = 0; i < DP; i++) begin
            ab2 = AW'(i);
            sb.push_back(8'h1F);
            tick;
            exp_px = sb.pop_front();
            n_cmp++;
            if (db2 !== exp_px) begin
                n_bad++;
                $display("FAIL clear_px%0d: got %h want %h", i, db2, exp_px);
            end
        end
        tick(4);
    endtask

    task automatic test_drop3;
        we3 = 1'b1; aa3 = 5'd2; da3 = 8'h61; tick;
        we3 = 1'b0; fd3 = 1'b1; tick;
        fd3 = 1'b0;
        n_cmp++;
        if (drop3 !== 1'b0 || rdy3o !== 1'b1) begin
            n_bad++;
            $display("FAIL drop3_first: got %b/%b want 0/1", drop3, rdy3o);
        end
        we3 = 1'b1; da3 = 8'h62; tick;
        we3 = 1'b0; fd3 = 1'b1; tick;
        fd3 = 1'b0;
        n_cmp++;
        if (drop3 !== 1'b1 || rdy3o !== 1'b1) begin
            n_bad++;
            $display("FAIL drop3_pulse: got %b/%b want 1/1", drop3, rdy3o);
        end
        tick;
        n_cmp++;
        if (drop3 !== 1'b0) begin
            n_bad++;
            $display("FAIL drop3_width: got %b want 0", drop3);
        end
        v3 = 1'b0;
        tick(3);
        n_cmp++;
        if (di3 !== 2'd0) begin
            n_bad++;
            $display("FAIL promo_early: got %0d want 0", di3);
        end
        tick;
        n_cmp++;
        if (di3 !== 2'd2 || fc3 !== 16'd1) begin
            n_bad++;
            $display("FAIL promo_disp: got %0d/%0d want 2/1", di3, fc3);
        end
        v3 = 1'b1;
        ab3 = 5'd2;
        sb.push_back(8'h62);
        tick;
        exp_px = sb.pop_front();
        n_cmp++;
        if (db3 !== exp_px) begin
            n_bad++;
            $display("FAIL promo_rd: got %h want %h", db3, exp_px);
        end
        tick(3);
        // no frame pending: a fall must not rotate
        v3 = 1'b0;
        tick(4);
        v3 = 1'b1;
        n_cmp++;
        if (di3 !== 2'd2 || fc3 !== 16'd1) begin
            n_bad++;
            $display("FAIL idle_fall: got %0d/%0d want 2/1", di3, fc3);
        end
        tick(4);
    endtask

    task automatic test_simul3;
        we3 = 1'b1; aa3 = 5'd9; da3 = 8'h99; tick;
        we3 = 1'b0; fd3 = 1'b1; tick;
        fd3 = 1'b0;
        we3 = 1'b1; da3 = 8'h77; tick;
        we3 = 1'b0; v3 = 1'b0;
        tick(3);
        fd3 = 1'b1; tick;
        fd3 = 1'b0; v3 = 1'b1;
        n_cmp++;
        if (di3 !== 2'd0 || fc3 !== 16'd2) begin
            n_bad++;
            $display("FAIL simul_disp: got %0d/%0d want 0/2", di3, fc3);
        end
        n_cmp++;
        if (drop3 !== 1'b1 || rdy3o !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_drop: got %b/%b want 1/1", drop3, rdy3o);
        end
        we3 = 1'b1; aa3 = 5'd9; da3 = 8'h5A; tick;
        we3 = 1'b0;
        ab3 = 5'd9;
        sb.push_back(8'h77);
        tick;
        exp_px = sb.pop_front();
        n_cmp++;
        if (db3 !== exp_px) begin
            n_bad++;
            $display("FAIL simul_rd: got %h want %h", db3, exp_px);
        end
    endtask

    task automatic test_rst_clear;
        ce2 = 1'b1; cc2 = 8'h3C;
        fd2 = 1'b1; tick;
        fd2 = 1'b0; v2 = 1'b0;
        tick(4);
        v2 = 1'b1;
        tick(8);
        n_cmp++;
        if (rdy2o !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_in_clear: got %b want 0", rdy2o);
        end
        rst = 1'b1; tick;
        rst = 1'b0; ce2 = 1'b0;
        n_cmp++;
        if (rdy2o !== 1'b1 || di2 !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_roles: got %b/%0d want 1/0", rdy2o, di2);
        end
        n_cmp++;
        if (fc2 !== 16'd0 || fc3 !== 16'd0 || di3 !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_cnt: got %0d/%0d/%0d want 0/0/0", fc2, fc3, di3);
        end
    endtask

    initial begin
        rst = 1'b1;
        v2 = 1'b1; we2 = 1'b0; fd2 = 1'b0; ce2 = 1'b0;
        aa2 = '0; ab2 = '0; da2 = '0; cc2 = '0;
        v3 = 1'b1; we3 = 1'b0; fd3 = 1'b0; ce3 = 1'b0;
        aa3 = '0; ab3 = '0; da3 = '0; cc3 = '0;
        test_reset;
        test_swap2;
        test_clear2;
        test_drop3;
        test_simul3;
        test_rst_clear;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/framebuffer_nbuf.md
# framebuffer_nbuf

Parametrised multi-buffered pixel store between the GPU rasteriser (write side) and the VGA scan-out (read side), replacing the fixed two-buffer scheme. Supports 2 (double) or 3 (triple) buffers, configurable pixel width and depth, and an explicit frame-done / swap handshake. An optional hardware clear engine fills each newly acquired draw buffer with a background colour. Buffer roles change only on the falling edge of the synchronised vsync.

## Interface

- NUM_BUFS, 2, buffer count; legal values 2 or 3
- PIXEL_WIDTH, 8, bits per pixel
- ADDR_WIDTH, 17, address bits
- DEPTH, 76800, pixels per buffer (320x240); must be ≤ 2^ADDR_WIDTH

Ports:

- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- vsync  in  1  VGA vsync, 25 MHz domain, asynchronous to clk
- wea  in  1  GPU pixel write strobe
- addra  in  ADDR_WIDTH  GPU write address
- dina  in  PIXEL_WIDTH  GPU write data
- frame_done  in  1  single-cycle pulse: draw buffer complete
- clear_en  in  1  enable clear of each new draw buffer
- clear_color  in  PIXEL_WIDTH  clear value, sampled when a clear starts
- draw_ready  out  1  high when GPU writes are accepted
- addrb  in  ADDR_WIDTH  scan-out read address
- doutb  out  PIXEL_WIDTH  scan-out pixel
- disp_idx  out  2  buffer currently displayed
- frame_count  out  16  number of completed swaps, wraps
- frame_dropped  out  1  pulse: a ready frame was overwritten before display

## Operation

- vsync passes through a 2-FF synchroniser; fall = prev & ~sync2, registered.
- Role registers: disp, draw, rdy (buffer indices), plus rdy_valid. Reset: disp=0, draw=1, rdy=2, rdy_valid=0, state DRAW, frame_count=0, draw_ready=1, frame_dropped=0.
- FSM states: DRAW, WAIT_SWAP, CLEAR.
- DRAW: wea with addra < DEPTH writes the draw buffer; addra ≥ DEPTH is ignored. On frame_done:
  - NUM_BUFS=2: go to WAIT_SWAP.
  - NUM_BUFS=3: rdy <= draw, rdy_valid <= 1, draw <= old rdy. If rdy_valid was already set, pulse frame_dropped. Go to CLEAR if clear_en, else DRAW.
- WAIT_SWAP (2-buf only): draw_ready=0; wea ignored. On fall: swap disp/draw, frame_count++. Go to CLEAR if clear_en, else DRAW.
- On fall in 3-buf mode with rdy_valid: disp <= rdy, rdy <= old disp, rdy_valid <= 0, frame_count++. This is independent of FSM state.
- 3-buf, frame_done and fall in the same cycle: the completing draw buffer goes directly to display; old disp becomes draw; old rdy stays the free slot with rdy_valid=0. Pulse frame_dropped if rdy_valid was set. frame_count++.
- CLEAR: draw_ready=0. Counter walks 0..DEPTH-1, writing the latched clear_color to the draw buffer, one pixel per cycle. After DEPTH-1, go to DRAW. GPU writes are ignored; frame_done is ignored. A fall during CLEAR still performs a 3-buf promotion, which never touches draw.
- Read side: addrb reads buffer disp. The display index is registered alongside the read, so doutb always comes from the buffer selected when addrb was presented, including across a swap.
- Non-display buffers are never read. Write ports of non-draw buffers have we=0.

## Timing

- Swap takes effect 4 clk cycles after the vsync falling edge at the pin: 2 sync FFs, edge register, role register.
- doutb read latency: 1 clk after addrb.
- Write: data is visible at read port from the cycle after the wea cycle, once that buffer is displayed.
- draw_ready drops in the cycle after frame_done (2-buf) or the clear start; it is registered.
- Clear duration: exactly DEPTH cycles. draw_ready rises the cycle after the last clear write.
- Mid-operation rst: all roles, counters and FSM return to reset values next cycle. Buffer contents are undefined (not cleared).

## Structure

- Package framebuffer_pkg: FSM state enum (FB_DRAW, FB_WAIT_SWAP, FB_CLEAR), default DEPTH/width constants, buffer index type.
- Sub-module fb_bram: inferred simple dual-port RAM (PIXEL_WIDTH x DEPTH, one write port, one registered read port). Instantiate it NUM_BUFS times via generate.
- Elaboration assertion: NUM_BUFS ∈ {2,3}, DEPTH ≤ 2^ADDR_WIDTH.

## Test plan

- Reset, 2-buf: disp_idx=0, draw_ready=1. Write 0xAA at addr 5, frame_done, vsync fall → disp_idx=1, then disp_idx=0 at the next frame. doutb at addr 5 = 0xAA once buffer 1 is displayed in the correct order, with 1-cycle latency.
- 2-buf WAIT_SWAP: frame_done, then wea at addr 7 with data 0x55 before vsync → write ignored, draw_ready=0. After the fall, draw_ready=1 and frame_count=1.
- clear_en=1, clear_color=0x1F, DEPTH=16 build: after swap, draw_ready low exactly 16 cycles. All 16 words read 0x1F once that buffer is displayed.
- 3-buf: two frame_done pulses without vsync → frame_dropped pulses once, draw_ready stays 1. Next fall → disp_idx = the last completed buffer.
- 3-buf simultaneous frame_done and fall → completing buffer displayed 4 cycles later, frame_count +1, no buffer both draw and disp.
- Assert rst during CLEAR at count 8 → next cycle state DRAW, draw_ready=1, disp_idx=0, frame_count=0.
